// File: rtl/vga_timing_driver_pkg.sv
// Shared VGA 640x480@60 timing constants and a counter-width helper
// used by the timing driver and its wrap-around counters.
package vga_timing_driver_pkg;

    localparam int COORD_W = 10;

    localparam int CLKS_PER_PIXEL_DEF = 2;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // A modulus of 1 still needs a one-bit register.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_driver_pixel_counter.sv
// Generic wrap-around counter with enable and terminal-count flag;
// used for the pixel divider, the column and the row.
module pixel_counter #(
    parameter int MODULUS = 2,
    parameter int W       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc    = (count_q == W'(MODULUS - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_driver.sv
// VGA timing generator: pixel divider, column/row counters, sync/blank
// decode and a single output register that keeps RGB, HS, VS, BLANK aligned.
module vga_timing_driver
    import vga_timing_driver_pkg::*;
#(
    parameter int CLKS_PER_PIXEL = CLKS_PER_PIXEL_DEF,
    parameter int H_VISIBLE      = H_VISIBLE_DEF,
    parameter int H_FP           = H_FP_DEF,
    parameter int H_SYNC         = H_SYNC_DEF,
    parameter int H_BP           = H_BP_DEF,
    parameter int V_VISIBLE      = V_VISIBLE_DEF,
    parameter int V_FP           = V_FP_DEF,
    parameter int V_SYNC         = V_SYNC_DEF,
    parameter int V_BP           = V_BP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [23:0]        pixel_color,
    output logic [COORD_W-1:0] VGA_row,
    output logic [COORD_W-1:0] VGA_col,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               vblank_start
);

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int DIV_W        = cnt_width(CLKS_PER_PIXEL);

    logic [DIV_W-1:0] div_count;
    logic             pix_tick;
    logic             col_tc;
    logic             row_tc;
    logic             row_en;

    pixel_counter #(.MODULUS(CLKS_PER_PIXEL), .W(DIV_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (div_count),
        .tc    (pix_tick)
    );

    pixel_counter #(.MODULUS(H_TOTAL), .W(COORD_W)) u_col (
        .clk   (clk),
        .rst   (rst),
        .en    (pix_tick),
        .count (VGA_col),
        .tc    (col_tc)
    );

    assign row_en = pix_tick & col_tc;

    pixel_counter #(.MODULUS(V_TOTAL), .W(COORD_W)) u_row (
        .clk   (clk),
        .rst   (rst),
        .en    (row_en),
        .count (VGA_row),
        .tc    (row_tc)
    );

    logic unused_ok;
    assign unused_ok = ^{div_count, row_tc};

    // Decode from the current (pre-increment) coordinates.
    logic visible, hs_active, vs_active;
    assign visible   = (VGA_col < COORD_W'(H_VISIBLE)) && (VGA_row < COORD_W'(V_VISIBLE));
    assign hs_active = (VGA_col >= COORD_W'(H_SYNC_START)) && (VGA_col < COORD_W'(H_SYNC_END));
    assign vs_active = (VGA_row >= COORD_W'(V_SYNC_START)) && (VGA_row < COORD_W'(V_SYNC_END));

    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic        vblank_q, vblank_d;

    always_comb begin
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (pix_tick) begin
            rgb_d     = visible ? pixel_color : 24'h0;
            hs_d      = ~hs_active;
            vs_d      = ~vs_active;
            blank_n_d = visible;
        end
        // High in the cycle where the counters first show (V_VISIBLE, 0).
        vblank_d = row_en && (VGA_row == COORD_W'(V_VISIBLE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q     <= 24'h0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            vblank_q  <= vblank_d;
        end
    end

    assign VGA_R        = rgb_q[23:16];
    assign VGA_G        = rgb_q[15:8];
    assign VGA_B        = rgb_q[7:0];
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench for vga_timing_driver using a shrunken raster so that
// full frames fit in a short run; expectations derive from edge counts.
module tb_vga_timing_driver;

    localparam int CPP = 2;
    localparam int HV = 20, HF = 4, HSY = 6, HB = 5;
    localparam int VV = 6,  VF = 2, VSY = 2, VB = 3;
    localparam int HT = HV + HF + HSY + HB;   // 35
    localparam int VT = VV + VF + VSY + VB;   // 13
    localparam int HS_START = HV + HF;        // 24
    localparam int HS_END   = HS_START + HSY; // 30
    localparam int VS_START = VV + VF;        // 8
    localparam int LINE_CLK  = HT * CPP;      // 70
    localparam int FRAME_CLK = VT * LINE_CLK; // 910

    logic        clk;
    logic        rst;
    logic [23:0] pixel_color;
    logic [9:0]  VGA_row, VGA_col;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, vblank_start;

    vga_timing_driver #(
        .CLKS_PER_PIXEL (CPP),
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_color  (pixel_color),
        .VGA_row      (VGA_row),
        .VGA_col      (VGA_col),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .VGA_BLANK_N  (VGA_BLANK_N),
        .vblank_start (vblank_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int edge_n = 0;

    // One rising edge, then park on the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        // Power-on reset values.
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL por_rgb: got %h want 0", {VGA_R, VGA_G, VGA_B}); else passed++;
        checks++; if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1) $display("FAIL por_sync: got hs=%b vs=%b want 1/1", VGA_HS, VGA_VS); else passed++;
        apply_reset();
        for (int i = 0; i < 30; i++) step();
        checks++; if (VGA_BLANK_N !== 1'b1) $display("FAIL pre_reset_blank: got %b want 1", VGA_BLANK_N); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (VGA_row !== 10'd0) $display("FAIL reset_row: got %0d want 0", VGA_row); else passed++;
        checks++; if (VGA_col !== 10'd0) $display("FAIL reset_col: got %0d want 0", VGA_col); else passed++;
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL reset_rgb: got %h want 0", {VGA_R, VGA_G, VGA_B}); else passed++;
        checks++; if (VGA_HS !== 1'b1) $display("FAIL reset_hs: got %b want 1", VGA_HS); else passed++;
        checks++; if (VGA_VS !== 1'b1) $display("FAIL reset_vs: got %b want 1", VGA_VS); else passed++;
        checks++; if (VGA_BLANK_N !== 1'b0) $display("FAIL reset_blank: got %b want 0", VGA_BLANK_N); else passed++;
        checks++; if (vblank_start !== 1'b0) $display("FAIL reset_vblank: got %b want 0", vblank_start); else passed++;
    endtask

    task automatic test_line_timing();
        int hs_fall = -1, hs_rise = -1, blank_clks = 0, wrap_edge = -1, blank_runs = 0;
        logic hs_prev = 1'b1, blank_prev = 1'b0;
        apply_reset();
        for (int i = 0; i < LINE_CLK + 4; i++) begin
            step();
            if (hs_prev && !VGA_HS && hs_fall < 0) hs_fall = edge_n;
            if (!hs_prev && VGA_HS && hs_rise < 0) hs_rise = edge_n;
            hs_prev = VGA_HS;
            if (edge_n <= LINE_CLK) begin
                if (VGA_BLANK_N) blank_clks++;
                if (VGA_BLANK_N && !blank_prev) blank_runs++;
                blank_prev = VGA_BLANK_N;
            end
            if (VGA_row == 10'd1 && wrap_edge < 0) wrap_edge = edge_n;
        end
        checks++; if (hs_fall !== (HS_START + 1) * CPP) $display("FAIL hs_fall_edge: got %0d want %0d", hs_fall, (HS_START + 1) * CPP); else passed++;
        checks++; if (hs_rise !== (HS_END + 1) * CPP) $display("FAIL hs_rise_edge: got %0d want %0d", hs_rise, (HS_END + 1) * CPP); else passed++;
        checks++; if (blank_clks !== HV * CPP) $display("FAIL blank_width: got %0d want %0d", blank_clks, HV * CPP); else passed++;
        checks++; if (blank_runs !== 1) $display("FAIL blank_runs: got %0d want 1", blank_runs); else passed++;
        checks++; if (wrap_edge !== LINE_CLK) $display("FAIL line_period: got %0d want %0d", wrap_edge, LINE_CLK); else passed++;
    endtask

    task automatic test_frame_timing();
        int seq_err = 0, range_err = 0, vs_fall = -1, vs_low = 0;
        int vb_count = 0, vb_first = -1, vb_second = -1, p;
        logic vs_prev = 1'b1;
        apply_reset();
        for (int i = 0; i < 2 * FRAME_CLK + 20; i++) begin
            step();
            p = edge_n / CPP;
            if (VGA_col !== 10'(p % HT) || VGA_row !== 10'((p / HT) % VT)) seq_err++;
            if (VGA_col >= 10'(HT) || VGA_row >= 10'(VT)) range_err++;
            if (vs_prev && !VGA_VS && vs_fall < 0) vs_fall = edge_n;
            vs_prev = VGA_VS;
            if (edge_n <= FRAME_CLK && !VGA_VS) vs_low++;
            if (vblank_start) begin
                vb_count++;
                if (vb_first < 0) vb_first = edge_n;
                else if (vb_second < 0) vb_second = edge_n;
            end
            if (edge_n == FRAME_CLK - CPP) begin
                checks++; if (VGA_row !== 10'(VT - 1) || VGA_col !== 10'(HT - 1)) $display("FAIL pre_wrap: got %0d,%0d want %0d,%0d", VGA_row, VGA_col, VT - 1, HT - 1); else passed++;
            end
            if (edge_n == FRAME_CLK) begin
                checks++; if (VGA_row !== 10'd0 || VGA_col !== 10'd0) $display("FAIL frame_wrap: got %0d,%0d want 0,0", VGA_row, VGA_col); else passed++;
            end
        end
        checks++; if (seq_err !== 0) $display("FAIL counter_seq: got %0d bad cycles want 0", seq_err); else passed++;
        checks++; if (range_err !== 0) $display("FAIL counter_range: got %0d bad cycles want 0", range_err); else passed++;
        checks++; if (vs_fall !== (VS_START * HT + 1) * CPP) $display("FAIL vs_fall_edge: got %0d want %0d", vs_fall, (VS_START * HT + 1) * CPP); else passed++;
        checks++; if (vs_low !== VSY * LINE_CLK) $display("FAIL vs_width: got %0d want %0d", vs_low, VSY * LINE_CLK); else passed++;
        checks++; if (vb_count !== 2) $display("FAIL vblank_count: got %0d want 2", vb_count); else passed++;
        checks++; if (vb_first !== VV * LINE_CLK) $display("FAIL vblank_first: got %0d want %0d", vb_first, VV * LINE_CLK); else passed++;
        checks++; if (vb_second - vb_first !== FRAME_CLK) $display("FAIL vblank_period: got %0d want %0d", vb_second - vb_first, FRAME_CLK); else passed++;
    endtask

    task automatic test_color_path();
        int blank_err = 0, rgb_err = 0, p, q, waits = 0;
        logic exp_vis;
        logic [23:0] exp_rgb;
        pixel_color = 24'hFF8000;
        apply_reset();
        for (int i = 0; i < FRAME_CLK; i++) begin
            step();
            p = edge_n / CPP;
            if (p >= 1) begin
                q = p - 1;
                exp_vis = ((q % HT) < HV) && (((q / HT) % VT) < VV);
                exp_rgb = exp_vis ? 24'hFF8000 : 24'h0;
                if (VGA_BLANK_N !== exp_vis) blank_err++;
                if ({VGA_R, VGA_G, VGA_B} !== exp_rgb) rgb_err++;
            end
        end
        checks++; if (blank_err !== 0) $display("FAIL blank_pattern: got %0d bad cycles want 0", blank_err); else passed++;
        checks++; if (rgb_err !== 0) $display("FAIL rgb_pattern: got %0d bad cycles want 0", rgb_err); else passed++;

        apply_reset();
        while (VGA_col != 10'd10 && waits < LINE_CLK) begin
            step();
            waits++;
        end
        checks++; if (VGA_col !== 10'd10) $display("FAIL switch_reach: got col %0d want 10", VGA_col); else passed++;
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFF8000) $display("FAIL switch_before: got %h want ff8000", {VGA_R, VGA_G, VGA_B}); else passed++;
        pixel_color = 24'h0000FF;
        step();
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFF8000) $display("FAIL switch_mid: got %h want ff8000", {VGA_R, VGA_G, VGA_B}); else passed++;
        step();
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0000FF || VGA_col !== 10'd11) $display("FAIL switch_after: got %h col %0d want 0000ff col 11", {VGA_R, VGA_G, VGA_B}, VGA_col); else passed++;
        pixel_color = 24'hFF8000;
    endtask

    task automatic test_mid_frame_reset();
        int waits = 0, vs_fall = -1;
        apply_reset();
        while (VGA_row != 10'(VS_START + 1) && waits < 2 * FRAME_CLK) begin
            step();
            waits++;
        end
        checks++; if (VGA_VS !== 1'b0) $display("FAIL midrst_vs_before: got %b want 0", VGA_VS); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (VGA_VS !== 1'b1) $display("FAIL midrst_vs: got %b want 1", VGA_VS); else passed++;
        checks++; if (VGA_row !== 10'd0 || VGA_col !== 10'd0) $display("FAIL midrst_cnt: got %0d,%0d want 0,0", VGA_row, VGA_col); else passed++;
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
        while (vs_fall < 0 && edge_n < FRAME_CLK + 10) begin
            step();
            if (!VGA_VS) vs_fall = edge_n;
        end
        checks++; if (vs_fall !== (VS_START * HT + 1) * CPP) $display("FAIL midrst_vs_restart: got %0d want %0d", vs_fall, (VS_START * HT + 1) * CPP); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        pixel_color = 24'hFF8000;
        #12;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_color_path();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_driver.md
# vga_timing_driver

Generates 640x480 @ 60 Hz VGA timing. Drives the pixel coordinates that the graphics pixel drivers consume, and takes back the 24-bit color they compute. The color is registered together with sync and blank, so the DAC sees aligned RGB, HS, VS and BLANK. The block sits between GraphicsTop and the board VGA DAC pins. It also emits a once-per-frame vertical-blank strobe so game logic can update playfield state without tearing.

## Interface
Parameters:
- CLKS_PER_PIXEL, 2: `clk` cycles per pixel (50 MHz `clk` gives 25 MHz pixel rate); legal values ≥1.
- H_VISIBLE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal segments in pixels; H_TOTAL = 800.
- V_VISIBLE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical segments in lines; V_TOTAL = 525.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pixel_color  in  24  {R,G,B} color for the current VGA_row/VGA_col, combinational from the graphics drivers.
- VGA_row  out  10  current line counter, 0..V_TOTAL-1.
- VGA_col  out  10  current pixel counter, 0..H_TOTAL-1.
- VGA_R / VGA_G / VGA_B  out  8 each  registered color.
- VGA_HS  out  1  horizontal sync, active-low, registered.
- VGA_VS  out  1  vertical sync, active-low, registered.
- VGA_BLANK_N  out  1  high while the registered pixel is visible.
- vblank_start  out  1  one-`clk` pulse when the counters enter row V_VISIBLE, col 0.

## Operation
- **Divider:** `div` counts 0..CLKS_PER_PIXEL-1 and wraps. `pix_tick` = (`div` == CLKS_PER_PIXEL-1). With CLKS_PER_PIXEL=1, `pix_tick` is high every cycle.
- **Counters:** on `pix_tick`, VGA_col increments. At H_TOTAL-1 it wraps to 0 and VGA_row increments. At row V_TOTAL-1 with col H_TOTAL-1, both wrap to 0. Counters never hold values ≥ the totals.
- **Visible region:** VGA_col < H_VISIBLE and VGA_row < V_VISIBLE.
- **Sync windows:** HS is asserted (low) for col in [656,752). VS is asserted (low) for row in [490,492). Both are computed as H_VISIBLE+H_FP through H_VISIBLE+H_FP+H_SYNC-1, and the vertical analogue.
- **Output stage (updates on `pix_tick` only):**
  - RGB ← visible ? pixel_color : 24'h0.
  - HS, VS, BLANK_N ← values decoded from the pre-increment counters.
  - Result: RGB, sync and blank always describe the same pixel.
- **vblank_start:** registered, high for exactly one `clk` following the `pix_tick` on which the counters become (row 480, col 0). It fires once per frame.
- **Reset values:**
  - `div`, VGA_row, VGA_col = 0.
  - VGA_R/G/B = 0.
  - VGA_HS = VGA_VS = 1.
  - VGA_BLANK_N = 0.
  - vblank_start = 0.
- **Reset mid-frame:** all state returns immediately (asynchronously) to the reset values. After release, timing restarts from (0,0) with a full first line. No partial sync pulse may extend past reset assertion.

## Timing
- **Counter advance:** counters advance on the `pix_tick` edge. With CLKS_PER_PIXEL=2, the first tick after reset release occurs on the 2nd rising `clk`.
- **Pipeline:** coordinate → DAC latency is 1 pixel period. The color sampled for (r,c) appears on VGA_R/G/B while the counters show the next pixel. pixel_color must settle within one `clk` of a counter change.
- **Period:** line = 800 pixels; frame = 420 000 pixels = 840 000 `clk` at CLKS_PER_PIXEL=2.
- **Pulse widths:** HS low 96 pixels per line. VS low 2 full lines (1600 pixels) per frame.
- **Upstream constraint:** vblank_start is safe for game-state updates for 45 lines (36 000 pixels) before row 0 restarts. Downstream state must be stable before then.

## Structure
- **DisplayPkg:** add the H_*/V_* timing constants, the derived H_TOTAL/V_TOTAL, and the sync start/end constants. Parameter defaults reference these.
- **Sub-module:** one natural sub-module, `pixel_counter`. It is a generic wrap-around counter with enable, terminal-count output and parameterized modulus. The divider, column and row all instantiate it.
- **Top-level:** the sync/blank decode and the output register stay in `vga_timing_driver`.

## Test plan
- **Reset:** assert `rst` asynchronously between edges. Outputs immediately take the reset values: RGB=0, HS=VS=1, BLANK_N=0, row=col=0.
- **Line timing:** release reset and count `pix_tick`s on one line.
  - VGA_HS falls on the output update for col 656 and rises at col 752.
  - BLANK_N is high for exactly 640 consecutive pixels.
  - Line period is 1600 `clk`.
- **Frame timing:** run 2 frames.
  - VS low for exactly 3200 `clk` starting at row 490.
  - vblank_start pulses exactly once per 840 000 `clk`, 1 `clk` wide.
- **Color path:**
  - pixel_color=24'hFF8000 held constant: RGB = FF/80/00 only while BLANK_N=1.
  - RGB = 0 at cols 640–799 and rows 480–524.
  - pixel_color switched at col 100 appears one pixel later.
- **Wrap boundary:** at row 524, col 799, the next tick gives row=0, col=0. No out-of-range count ever appears (assertion held over the full run).
- **Mid-frame reset:** assert `rst` at row 491 (VS low). VS returns to 1 immediately. After release, the first VS assertion occurs 490 lines later.
